sme_result_collector: RTL

Downstream stage of the string-matching engine. It captures each one-cycle result pulse (`valid`, `match`, `match_index`) that the engine raises at the end of a string/pattern query. Each result is tagged with a query sequence number and buffered in a small show-ahead FIFO. Results drain to the host over a valid/ready handshake, and running query, match and drop statistics are kept.

---
 rtl/sme_result_collector.sv | 95 +++++++++
 1 files changed

// File: rtl/sme_result_collector.sv
// Result collector for the string-matching engine: tags each result pulse with a
// sequence number, buffers it in a show-ahead FIFO and keeps saturating statistics.
module sme_result_collector #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 5,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       sme_valid,
  input  logic                       sme_match,
  input  logic [IDX_W-1:0]           sme_match_index,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [CNT_W-1:0]           res_seq,
  output logic                       res_match,
  output logic [IDX_W-1:0]           res_index,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           query_cnt,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [CNT_W-1:0] seq;

  logic [CNT_W-1:0] mem_seq   [DEPTH];
  logic             mem_match [DEPTH];
  logic [IDX_W-1:0] mem_idx   [DEPTH];

  logic empty;
  logic full;
  logic push_try;
  logic push_ok;
  logic pop;
  logic drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop      = !empty && res_ready;
  assign push_try = sme_valid && !clr;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok  = push_try && (!full || pop);
  assign drop     = push_try && full && !pop;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      seq       <= '0;
      query_cnt <= '0;
      match_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_try) begin
        seq       <= seq + CNT_W'(1);
        query_cnt <= sat_inc(query_cnt);
        if (sme_match) match_cnt <= sat_inc(match_cnt);
      end
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: an entry is only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_seq[wr_ptr[AW-1:0]]   <= seq;
      mem_match[wr_ptr[AW-1:0]] <= sme_match;
      mem_idx[wr_ptr[AW-1:0]]   <= sme_match ? sme_match_index : '0;
    end
  end

  assign level     = LW'(wr_ptr - rd_ptr);
  assign res_valid = !empty;
  assign res_seq   = empty ? '0   : mem_seq[rd_ptr[AW-1:0]];
  assign res_match = empty ? 1'b0 : mem_match[rd_ptr[AW-1:0]];
  assign res_index = empty ? '0   : mem_idx[rd_ptr[AW-1:0]];

endmodule
